// File: rtl/tpu_pkg.sv
// Shared TPU types: instruction word layout, address widths and opcode flag positions.
package tpu_pkg;

    typedef logic [7:0]  opcode_type;
    typedef logic [31:0] length_type;
    typedef logic [15:0] accumulator_addr_type;
    typedef logic [23:0] buffer_addr_type;

    typedef struct packed {
        opcode_type           opcode;
        length_type           length;
        accumulator_addr_type acc_addr;
        buffer_addr_type      buffer_addr;
    } instr_type;

    localparam int unsigned OPC_ACCUMULATE_BIT = 0;
    localparam int unsigned OPC_SIGNED_BIT     = 1;

    typedef enum logic {
        MM_IDLE,
        MM_READ
    } mm_state_e;

endpackage

// File: rtl/matmul_flow_controller_if.sv
// Instruction handshake plus unified-buffer / MMU / accumulator control bus of the matmul controller.
interface matmul_flow_controller_if;
    import tpu_pkg::*;

    instr_type            instr;
    logic                 instr_enable;
    buffer_addr_type      buf_read_addr;
    logic                 buf_read_en;
    logic                 mmu_sds_en;
    logic                 mmu_signed;
    logic                 activate_weight;
    accumulator_addr_type acc_write_addr;
    logic                 acc_write_en;
    logic                 accumulate;
    logic                 busy;
    logic                 resource_busy;

    // master issues instructions and consumes the control strobes
    modport master (
        output instr, instr_enable,
        input  buf_read_addr, buf_read_en, mmu_sds_en, mmu_signed, activate_weight,
        input  acc_write_addr, acc_write_en, accumulate, busy, resource_busy
    );

    modport slave (
        input  instr, instr_enable,
        output buf_read_addr, buf_read_en, mmu_sds_en, mmu_signed, activate_weight,
        output acc_write_addr, acc_write_en, accumulate, busy, resource_busy
    );

endinterface

// File: rtl/matmul_write_delay.sv
// Enable-gated DEPTH-stage shift line carrying accumulator write address, accumulate flag and valid.
module matmul_write_delay
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 push_valid,
    input  accumulator_addr_type push_addr,
    input  logic                 push_accumulate,
    output logic                 pop_valid,
    output accumulator_addr_type pop_addr,
    output logic                 pop_accumulate,
    output logic                 any_valid
);

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     acc_q;
    accumulator_addr_type addr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            acc_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
            end
        end else if (enable) begin
            valid_q <= {valid_q[DEPTH-2:0], push_valid};
            acc_q   <= {acc_q[DEPTH-2:0], push_accumulate};
            addr_q[0] <= push_addr;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign pop_valid      = valid_q[DEPTH-1];
    assign pop_accumulate = acc_q[DEPTH-1];
    assign pop_addr       = addr_q[DEPTH-1];
    assign any_valid      = |valid_q;

endmodule

// File: rtl/matmul_flow_controller.sv
// Sequences unified-buffer reads into the systolic array and the delayed accumulator writes.
// Optional MATMUL_PERF_COUNTER_EN adds a saturating busy_cycles counter port.
module matmul_flow_controller
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    matmul_flow_controller_if.slave  bus
`ifdef MATMUL_PERF_COUNTER_EN
    ,
    output logic [31:0]              busy_cycles
`endif
);

    localparam int unsigned LAT = MATRIX_WIDTH + 3;

    mm_state_e            state;
    length_type           remaining;
    buffer_addr_type      read_addr;
    accumulator_addr_type row_acc_addr;
    logic                 read_en;
    logic                 act_pulse;
    logic                 acc_flag;
    logic                 signed_flag;

    logic                 pipe_any_valid;
    logic                 busy_int;

    // read_en doubles as resource_busy: IDLE is the only state that accepts
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= MM_IDLE;
            remaining    <= '0;
            read_addr    <= '0;
            row_acc_addr <= '0;
            read_en      <= 1'b0;
            act_pulse    <= 1'b0;
            acc_flag     <= 1'b0;
            signed_flag  <= 1'b0;
        end else if (enable) begin
            case (state)
                MM_IDLE: begin
                    if (bus.instr_enable && (bus.instr.length != '0)) begin
                        state        <= MM_READ;
                        remaining    <= bus.instr.length - length_type'(1);
                        read_addr    <= bus.instr.buffer_addr;
                        row_acc_addr <= bus.instr.acc_addr;
                        acc_flag     <= bus.instr.opcode[OPC_ACCUMULATE_BIT];
                        signed_flag  <= bus.instr.opcode[OPC_SIGNED_BIT];
                        read_en      <= 1'b1;
                        act_pulse    <= 1'b1;
                    end
                end
                MM_READ: begin
                    act_pulse <= 1'b0;
                    if (remaining == '0) begin
                        state       <= MM_IDLE;
                        read_en     <= 1'b0;
                        signed_flag <= 1'b0;
                    end else begin
                        remaining    <= remaining - length_type'(1);
                        read_addr    <= read_addr + buffer_addr_type'(1);
                        row_acc_addr <= row_acc_addr + accumulator_addr_type'(1);
                    end
                end
                default: state <= MM_IDLE;
            endcase
        end
    end

    // payload is zeroed when no row is read so idle write outputs stay 0
    matmul_write_delay #(
        .DEPTH (LAT)
    ) u_write_delay (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .push_valid      (read_en),
        .push_addr       (read_en ? row_acc_addr : '0),
        .push_accumulate (read_en & acc_flag),
        .pop_valid       (bus.acc_write_en),
        .pop_addr        (bus.acc_write_addr),
        .pop_accumulate  (bus.accumulate),
        .any_valid       (pipe_any_valid)
    );

    assign busy_int            = read_en | pipe_any_valid;
    assign bus.busy            = busy_int;
    assign bus.resource_busy   = read_en;
    assign bus.buf_read_en     = read_en;
    assign bus.mmu_sds_en      = read_en;
    assign bus.buf_read_addr   = read_addr;
    assign bus.activate_weight = act_pulse;
    assign bus.mmu_signed      = signed_flag;

`ifdef MATMUL_PERF_COUNTER_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_cycles <= '0;
        end else if (enable && busy_int && (busy_cycles != '1)) begin
            busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matmul_flow_controller.sv
// Directed self-checking bench for matmul_flow_controller (MATRIX_WIDTH=14, write latency 17).
module tb_matmul_flow_controller;
    import tpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;

    matmul_flow_controller_if bus();

`ifdef MATMUL_PERF_COUNTER_EN
    logic [31:0] busy_cycles;
`endif

    matmul_flow_controller #(
        .MATRIX_WIDTH (14)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
`ifdef MATMUL_PERF_COUNTER_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // event log, filled only on enabled, out-of-reset cycles
    int          cyc = 0;
    int          ecyc = 0;
    logic [31:0] rd_addr[$];
    logic        rd_sig[$];
    int          rd_e[$];
    int          rd_c[$];
    logic [31:0] wr_addr[$];
    logic        wr_acc[$];
    int          wr_e[$];
    int          act_n = 0;
    logic        busy_seen = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && enable) begin
            if (bus.buf_read_en) begin
                rd_addr.push_back({8'h00, bus.buf_read_addr});
                rd_sig.push_back(bus.mmu_signed);
                rd_e.push_back(ecyc);
                rd_c.push_back(cyc);
            end
            if (bus.acc_write_en) begin
                wr_addr.push_back({16'h0000, bus.acc_write_addr});
                wr_acc.push_back(bus.accumulate);
                wr_e.push_back(ecyc);
            end
            if (bus.activate_weight) act_n++;
            if (bus.busy) busy_seen = 1'b1;
            ecyc++;
        end
    end

    function automatic instr_type mk(input logic [7:0] op, input logic [31:0] len,
                                     input logic [15:0] acc, input logic [23:0] ba);
        instr_type t;
        t.opcode      = op;
        t.length      = len;
        t.acc_addr    = acc;
        t.buffer_addr = ba;
        return t;
    endfunction

    task automatic clear_log();
        rd_addr.delete(); rd_sig.delete(); rd_e.delete(); rd_c.delete();
        wr_addr.delete(); wr_acc.delete(); wr_e.delete();
        act_n = 0;
        busy_seen = 1'b0;
    endtask

    task automatic issue(input instr_type i);
        bus.instr = i;
        bus.instr_enable = 1'b1;
        @(posedge clk); #1;
        bus.instr_enable = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while ((bus.busy || bus.resource_busy) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_strobes"},
                 {24'd0, bus.buf_read_en, bus.mmu_sds_en, bus.mmu_signed, bus.activate_weight,
                  bus.acc_write_en, bus.accumulate, bus.busy, bus.resource_busy}, 32'd0);
        check_eq({tag, "_rdaddr"}, {8'h00, bus.buf_read_addr}, 32'd0);
        check_eq({tag, "_wraddr"}, {16'h0000, bus.acc_write_addr}, 32'd0);
    endtask

    task automatic check_batch(input string tag, input int first, input int n,
                               input logic [31:0] rbase, input logic [31:0] wbase,
                               input logic acc, input logic sig);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_rd%0d", tag, i), rd_addr[first+i], (rbase + i) & 32'h00FF_FFFF);
            check_eq($sformatf("%s_sig%0d", tag, i), {31'd0, rd_sig[first+i]}, {31'd0, sig});
            check_eq($sformatf("%s_wr%0d", tag, i), wr_addr[first+i], (wbase + i) & 32'h0000_FFFF);
            check_eq($sformatf("%s_acc%0d", tag, i), {31'd0, wr_acc[first+i]}, {31'd0, acc});
            check_eq($sformatf("%s_lat%0d", tag, i), wr_e[first+i] - rd_e[first+i], 32'd17);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        instr_type ia, ib;

        // reset held with a valid strobe present: must stay idle
        bus.instr = mk(8'h23, 32'd5, 16'h0946, 24'h000084);
        bus.instr_enable = 1'b1;
        enable = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        bus.instr_enable = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("reset_no_accept", {31'd0, bus.busy}, 32'd0);

        // basic signed/accumulate batch
        clear_log();
        ia = mk(8'h23, 32'd5, 16'h0946, 24'h000084);
        issue(ia);
        check_eq("t1_rbusy", {31'd0, bus.resource_busy}, 32'd1);
        check_eq("t1_act", {31'd0, bus.activate_weight}, 32'd1);
        wait_idle(60, "t1");
        check_eq("t1_nrd", rd_addr.size(), 32'd5);
        check_eq("t1_nwr", wr_addr.size(), 32'd5);
        check_eq("t1_nact", act_n, 32'd1);
        if (rd_addr.size() == 5 && wr_addr.size() == 5)
            check_batch("t1", 0, 5, 32'h84, 32'h0946, 1'b1, 1'b1);

        // zero length is a no-op
        clear_log();
        issue(mk(8'h03, 32'd0, 16'h0010, 24'h000020));
        repeat (25) @(posedge clk);
        #1;
        check_eq("t2_nrd", rd_addr.size(), 32'd0);
        check_eq("t2_nwr", wr_addr.size(), 32'd0);
        check_eq("t2_busy", {31'd0, busy_seen}, 32'd0);
        check_eq("t2_nact", act_n, 32'd0);

        // refused while resource_busy, then accepted back-to-back
        clear_log();
        ib = mk(8'h00, 32'd3, 16'h0100, 24'h000200);
        issue(ia);
        bus.instr = ib;
        bus.instr_enable = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.instr_enable = 1'b0;
        k = 0;
        while (bus.resource_busy && k < 20) begin @(posedge clk); #1; k++; end
        check_eq("t3_rbusy_fall", {31'd0, bus.resource_busy}, 32'd0);
        issue(ib);
        wait_idle(80, "t3");
        check_eq("t3_nrd", rd_addr.size(), 32'd8);
        check_eq("t3_nwr", wr_addr.size(), 32'd8);
        check_eq("t3_nact", act_n, 32'd2);
        if (rd_addr.size() == 8 && wr_addr.size() == 8) begin
            check_batch("t3a", 0, 5, 32'h84, 32'h0946, 1'b1, 1'b1);
            check_batch("t3b", 5, 3, 32'h200, 32'h0100, 1'b0, 1'b0);
            check_eq("t3_gap", rd_e[5] - rd_e[4], 32'd2);
        end

        // 4-cycle freeze in the middle of the read phase
        clear_log();
        issue(mk(8'h01, 32'd6, 16'h0020, 24'h000010));
        repeat (2) begin @(posedge clk); #1; end
        enable = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check_eq("t4_hold_addr", {8'h00, bus.buf_read_addr}, 32'h12);
        check_eq("t4_hold_en", {31'd0, bus.buf_read_en}, 32'd1);
        enable = 1'b1;
        wait_idle(80, "t4");
        check_eq("t4_nrd", rd_addr.size(), 32'd6);
        check_eq("t4_nwr", wr_addr.size(), 32'd6);
        check_eq("t4_nact", act_n, 32'd1);
        if (rd_addr.size() == 6 && wr_addr.size() == 6) begin
            check_batch("t4", 0, 6, 32'h10, 32'h0020, 1'b1, 1'b0);
            check_eq("t4_stretch", rd_c[5] - rd_c[0], 32'd9);
        end

        // address wrap on both buffer and accumulator
        clear_log();
        issue(mk(8'h02, 32'd3, 16'hFFFF, 24'hFFFFFE));
        wait_idle(60, "t5");
        check_eq("t5_nrd", rd_addr.size(), 32'd3);
        check_eq("t5_nwr", wr_addr.size(), 32'd3);
        if (rd_addr.size() == 3 && wr_addr.size() == 3)
            check_batch("t5", 0, 3, 32'hFFFFFE, 32'hFFFF, 1'b0, 1'b1);
        check_eq("t5_signed_off", {31'd0, bus.mmu_signed}, 32'd0);

        // reset during the write tail discards the remaining rows
        clear_log();
        issue(mk(8'h01, 32'd4, 16'h0300, 24'h000400));
        k = 0;
        while (!bus.acc_write_en && k < 40) begin @(posedge clk); #1; k++; end
        check_eq("t6_wr_seen", {31'd0, bus.acc_write_en}, 32'd1);
        rst = 1'b0;
        bus.instr = mk(8'h03, 32'd2, 16'h0500, 24'h000600);
        bus.instr_enable = 1'b1;
        @(posedge clk); #1;
        check_all_zero("t6_rst");
        rst = 1'b1;
        bus.instr_enable = 1'b0;
        clear_log();
        repeat (30) @(posedge clk);
        #1;
        check_eq("t6_nwr", wr_addr.size(), 32'd0);
        check_eq("t6_nrd", rd_addr.size(), 32'd0);
        check_eq("t6_busy", {31'd0, busy_seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
